// File: rtl/riscv_dcache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// One word per line; misses stall the pipeline while a req/ack handshake runs to backing memory.
module riscv_dcache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  stall,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - 2;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL,
    S_FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];
  logic                line_we;
  logic [IDX_W-1:0]    line_idx;
  logic [TAG_W-1:0]    tag_d;
  logic [DATA_W-1:0]   data_d;

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic                miss;
  logic                unused_addr_lsbs;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  assign req_idx          = req_addr[IDX_W+1:2];
  assign req_tag          = req_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr_lsbs = ^req_addr[1:0];
  assign hit              = req_valid & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign miss             = req_valid & ~hit;

  assign rdata      = data_q[req_idx];
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    line_we    = 1'b0;
    line_idx   = req_idx;
    tag_d      = req_tag;
    data_d     = merge_bytes(data_q[req_idx], req_wdata, req_wstrb);
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    flush_done = 1'b0;
    stall      = (state_q != S_IDLE) | miss;

    case (state_q)
      S_IDLE: begin
        if (miss) begin
          miss_idx_d = req_idx;
          miss_tag_d = req_tag;
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d    = (valid_q[req_idx] & dirty_q[req_idx]) ? S_WRITEBACK : S_REFILL;
        end else begin
          if (hit) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
            if (req_we) begin
              line_we          = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end
          end
          if (flush_req) begin
            state_d = S_FLUSH;
            ptr_d   = '0;
          end
        end
      end

      // Victim address and data come from the stored line, so they hold until ack.
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[miss_idx_q], miss_idx_q, 2'b00};
        mem_wdata = data_q[miss_idx_q];
        if (mem_ack) begin
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = S_REFILL;
        end
      end

      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, miss_idx_q, 2'b00};
        if (mem_ack) begin
          line_we             = 1'b1;
          line_idx            = miss_idx_q;
          tag_d               = miss_tag_q;
          data_d              = mem_rdata;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = S_IDLE;
        end
      end

      // A dirty line is written back first; the following cycle sees it clean and advances.
      S_FLUSH: begin
        if (valid_q[ptr_q] & dirty_q[ptr_q]) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {tag_q[ptr_q], ptr_q, 2'b00};
          mem_wdata = data_q[ptr_q];
          if (mem_ack) dirty_d[ptr_q] = 1'b0;
        end else if (ptr_q == LAST_IDX) begin
          flush_done = 1'b1;
          ptr_d      = '0;
          state_d    = S_IDLE;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    miss_idx_q <= miss_idx_d;
    miss_tag_q <= miss_tag_d;
    if (line_we) begin
      tag_q[line_idx]  <= tag_d;
      data_q[line_idx] <= data_d;
    end
  end

endmodule
